// File: rtl/freq_div_ctrl.sv
// rtl/freq_div_ctrl.sv - programmable clock divider with glitch-free ratio change handshake
// Optional feature: define FREQ_DIV_CTRL_CNT_EN to add the 16-bit period_cnt output.
module freq_div_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEF_RATIO = 6
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             en,
  input  logic             req,
  input  logic [WIDTH-1:0] ratio,
  output logic             ack,
  output logic             busy,
  output logic             tick,
`ifdef FREQ_DIV_CTRL_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             clk_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [WIDTH-1:0] DEF_N   = DEF_RATIO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_N   = {{(WIDTH-2){1'b0}}, 2'b10};
  localparam logic [WIDTH-1:0] ONE_N   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] act_n, act_d;
  logic [WIDTH-1:0] pend_n, pend_d;
  logic             busy_d;
  logic             ack_d;
  logic             tick_d;
  logic             clk_out_d;
  logic             wrap;
  logic [WIDTH-1:0] ratio_safe;

  // Ratios below 2 cannot form a period with both a high and low phase.
  assign ratio_safe = (ratio < MIN_N) ? MIN_N : ratio;

  // Last cycle of the current period; >= guards against any out-of-range count.
  assign wrap = (state != IDLE) && (cnt >= (act_n - ONE_N));

  // Next-state logic: period counting, run/stop sequencing and ratio handoff.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    act_d   = act_n;
    pend_d  = pend_n;
    busy_d  = busy;
    ack_d   = 1'b0;
    tick_d  = 1'b0;

    case (state)
      IDLE: begin
        cnt_d = '0;
        // No period in flight, so a pending ratio can take effect at once,
        // which also places it ahead of the first period when en rises.
        if (busy) begin
          act_d  = pend_n;
          busy_d = 1'b0;
          ack_d  = 1'b1;
        end
        if (en) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (busy) begin
            act_d  = pend_n;
            busy_d = 1'b0;
            ack_d  = 1'b1;
          end
          // Dropping en exactly on the last cycle ends the run cleanly.
          if (!en) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + ONE_N;
          if (!en) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (wrap) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (busy) begin
            act_d  = pend_n;
            busy_d = 1'b0;
            ack_d  = 1'b1;
          end
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d = cnt + ONE_N;
          // Re-enable resumes the same period without truncating it.
          if (en) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Capture only when nothing is pending; busy is low here so this
    // never collides with an apply in the same cycle.
    if (req && !busy) begin
      pend_d = ratio_safe;
      busy_d = 1'b1;
    end
  end

  // Divided clock follows the count and ratio that will be live next cycle.
  assign clk_out_d = (state_d != IDLE) && (cnt_d < (act_d >> 1));

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      act_n   <= DEF_N;
      pend_n  <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      act_n   <= act_d;
      pend_n  <= pend_d;
      busy    <= busy_d;
      ack     <= ack_d;
      tick    <= tick_d;
      clk_out <= clk_out_d;
    end
  end

`ifdef FREQ_DIV_CTRL_CNT_EN
  // Count completed periods; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= period_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// tb/tb_freq_div_ctrl.sv - directed self-checking bench for freq_div_ctrl
module tb_freq_div_ctrl;

  logic       rst;
  logic       clk;
  logic       en;
  logic       req;
  logic [7:0] ratio;
  logic       ack;
  logic       busy;
  logic       tick;
  logic       clk_out;

  int vec_cnt;
  int err_cnt;

  freq_div_ctrl #(.WIDTH(8), .DEF_RATIO(6)) dut (
    .rst     (rst),
    .clk     (clk),
    .en      (en),
    .req     (req),
    .ratio   (ratio),
    .ack     (ack),
    .busy    (busy),
    .tick    (tick),
    .clk_out (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input bit t, input bit c, input bit a, input bit b);
    check_val({tag, "_tick"}, {31'd0, tick}, {31'd0, t});
    check_val({tag, "_clk"},  {31'd0, clk_out}, {31'd0, c});
    check_val({tag, "_ack"},  {31'd0, ack}, {31'd0, a});
    check_val({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  task automatic step_chk(input string tag, input bit t, input bit c, input bit a, input bit b);
    @(posedge clk);
    #1;
    check_outs(tag, t, c, a, b);
  endtask

  // One full period of ratio n starting at cnt==0, nothing pending afterwards.
  task automatic run_period(input string tag, input int n, input bit t0, input bit a0);
    for (int i = 0; i < n; i++) begin
      step_chk(tag, (i == 0) ? t0 : 1'b0, (i < n / 2), (i == 0) ? a0 : 1'b0, 1'b0);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst   = 1'b0;
    en    = 1'b0;
    req   = 1'b0;
    ratio = 8'd0;

    // Reset state
    #3;
    check_outs("rst0", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_chk("idle", 0, 0, 0, 0);

    // Default ratio 6: 3 high / 3 low, tick every 6
    en = 1'b1;
    run_period("p6a", 6, 0, 0);
    run_period("p6b", 6, 1, 0);
    run_period("p6c", 6, 1, 0);

    // Change to 4 requested at cnt==1
    step_chk("r4c0", 1, 1, 0, 0);
    step_chk("r4c1", 0, 1, 0, 0);
    req = 1'b1; ratio = 8'd4;
    step_chk("r4c2", 0, 1, 0, 1);
    req = 1'b0;
    step_chk("r4c3", 0, 0, 0, 1);
    step_chk("r4c4", 0, 0, 0, 1);
    step_chk("r4c5", 0, 0, 0, 1);
    run_period("p4a", 4, 1, 1);
    run_period("p4b", 4, 1, 0);

    // Request on the wrap cycle: captured only, ratio 5 applied a period later
    req = 1'b1; ratio = 8'd5;
    step_chk("r5c0", 1, 1, 0, 1);
    req = 1'b0;
    step_chk("r5c1", 0, 1, 0, 1);
    step_chk("r5c2", 0, 0, 0, 1);
    step_chk("r5c3", 0, 0, 0, 1);
    run_period("p5a", 5, 1, 1);
    run_period("p5b", 5, 1, 0);

    // Ratio 1 coerced to 2
    step_chk("r1c0", 1, 1, 0, 0);
    req = 1'b1; ratio = 8'd1;
    step_chk("r1c1", 0, 1, 0, 1);
    req = 1'b0;
    step_chk("r1c2", 0, 0, 0, 1);
    step_chk("r1c3", 0, 0, 0, 1);
    step_chk("r1c4", 0, 0, 0, 1);
    run_period("p2a", 2, 1, 1);
    run_period("p2b", 2, 1, 0);
    run_period("p2c", 2, 1, 0);

    // Second request while busy is ignored
    step_chk("r6c0", 1, 1, 0, 0);
    req = 1'b1; ratio = 8'd6;
    step_chk("r6c1", 0, 0, 0, 1);
    ratio = 8'd9;
    step_chk("r9ign", 1, 1, 1, 0);
    req = 1'b0;
    step_chk("r6d1", 0, 1, 0, 0);
    step_chk("r6d2", 0, 1, 0, 0);
    step_chk("r6d3", 0, 0, 0, 0);
    step_chk("r6d4", 0, 0, 0, 0);
    step_chk("r6d5", 0, 0, 0, 0);
    run_period("p6d", 6, 1, 0);

    // en dropped at cnt==2: finish the period, final tick, then idle
    step_chk("st0", 1, 1, 0, 0);
    step_chk("st1", 0, 1, 0, 0);
    step_chk("st2", 0, 1, 0, 0);
    en = 1'b0;
    step_chk("st3", 0, 0, 0, 0);
    step_chk("st4", 0, 0, 0, 0);
    step_chk("st5", 0, 0, 0, 0);
    step_chk("stwrap", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step_chk("stidle", 0, 0, 0, 0);

    // Pending ratio in IDLE applied before first RUN period
    req = 1'b1; ratio = 8'd3;
    step_chk("i3cap", 0, 0, 0, 1);
    req = 1'b0; en = 1'b1;
    step_chk("i3c0", 0, 1, 1, 0);
    step_chk("i3c1", 0, 0, 0, 0);
    step_chk("i3c2", 0, 0, 0, 0);
    run_period("p3a", 3, 1, 0);

    // Back to 6, then reset with a request pending at cnt==3
    req = 1'b1; ratio = 8'd6;
    step_chk("b6c0", 1, 1, 0, 1);
    req = 1'b0;
    step_chk("b6c1", 0, 0, 0, 1);
    step_chk("b6c2", 0, 0, 0, 1);
    run_period("p6e", 6, 1, 1);
    step_chk("pr0", 1, 1, 0, 0);
    step_chk("pr1", 0, 1, 0, 0);
    step_chk("pr2", 0, 1, 0, 0);
    req = 1'b1; ratio = 8'd4;
    step_chk("pr3", 0, 0, 0, 1);
    req = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check_outs("rstmid", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("rsthold", 0, 0, 0, 0);
    rst = 1'b1;
    run_period("p6f", 6, 0, 0);
    run_period("p6g", 6, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
